// File: rtl/conv_pkg.sv
// Shared definitions for the slow conv path: default geometry, index width
// helper and the window serializer state encoding.
package conv_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_K      = 3;

  // Width of an element index into an n-element window; never below 1 bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } conv_state_t;

endpackage

// File: rtl/conv_mux_n.sv
// Parametrised N:1 element select over a flattened bus. Element i lives at
// in_bus[i*DATA_W +: DATA_W]; a select at or beyond N returns zero.
module conv_mux_n
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_K * DEF_K,
  parameter int IDX_W  = idx_width(N)
) (
  input  logic [N*DATA_W-1:0] in_bus,
  input  logic [IDX_W-1:0]    sel,
  output logic [DATA_W-1:0]   dout
);

  // Priority-free one-hot match; no match (out of range) leaves the zero default.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == IDX_W'(i)) begin
        dout = in_bus[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/conv_window_serializer.sv
// Captures one KxK window in a single handshake and streams it out one
// element per cycle, row-major, with index and last flag. Back-to-back
// windows are accepted on the last beat so throughput is N cycles/window.
module conv_window_serializer
  import conv_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int K      = DEF_K,
  localparam int N      = K * K,
  localparam int IDX_W  = idx_width(K * K)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  conv_state_t         state, state_nx;
  logic [IDX_W-1:0]    cnt, cnt_nx;
  logic [N*DATA_W-1:0] win, win_nx;
  logic [DATA_W-1:0]   sel_data;
  logic                is_last;
  logic                fire;
  logic                accept;

  conv_mux_n #(
    .DATA_W (DATA_W),
    .N      (N),
    .IDX_W  (IDX_W)
  ) u_sel (
    .in_bus (win),
    .sel    (cnt),
    .dout   (sel_data)
  );

  // State, element counter and window register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      win   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      win   <= win_nx;
    end
  end

  // Handshakes and next state. Outputs come only from registered state;
  // in_ready alone sees out_ready combinationally so a new window can be
  // taken in the same cycle the last beat leaves.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    win_nx    = win;
    busy      = (state == ST_SEND);
    is_last   = (state == ST_SEND) && (cnt == LAST_IDX);
    out_valid = (state == ST_SEND) && !abort;
    out_data  = (state == ST_SEND) ? sel_data : '0;
    out_idx   = cnt;
    out_last  = is_last;
    fire      = out_valid && out_ready;
    in_ready  = !abort && ((state == ST_IDLE) || (is_last && out_ready));
    accept    = in_valid && in_ready;

    if (abort) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else if (accept) begin
      win_nx   = in_data;
      cnt_nx   = '0;
      state_nx = ST_SEND;
    end else if (fire) begin
      if (is_last) begin
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end else begin
        cnt_nx = cnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_window_serializer.sv
// Directed bench for conv_window_serializer: default geometry plus K=1
// (DATA_W=16) and K=5 instances. Inputs change and outputs are sampled just
// after the falling edge.
module tb_conv_window_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Default instance: K=3, DATA_W=8
  logic        abort0 = 0, in_valid0 = 0, out_ready0 = 0;
  logic [71:0] in_data0 = '0;
  logic        in_ready0, out_valid0, out_last0, busy0;
  logic [7:0]  out_data0;
  logic [3:0]  out_idx0;

  conv_window_serializer #(.DATA_W(8), .K(3)) dut0 (
    .clk(clk), .rst(rst), .abort(abort0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_idx(out_idx0), .out_last(out_last0), .busy(busy0));

  // K=1, DATA_W=16
  logic        abort1 = 0, in_valid1 = 0, out_ready1 = 0;
  logic [15:0] in_data1 = '0;
  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [15:0] out_data1;
  logic [0:0]  out_idx1;

  conv_window_serializer #(.DATA_W(16), .K(1)) dut1 (
    .clk(clk), .rst(rst), .abort(abort1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1), .busy(busy1));

  // K=5, DATA_W=8
  logic         abort2 = 0, in_valid2 = 0, out_ready2 = 0;
  logic [199:0] in_data2 = '0;
  logic         in_ready2, out_valid2, out_last2, busy2;
  logic [7:0]   out_data2;
  logic [4:0]   out_idx2;

  conv_window_serializer #(.DATA_W(8), .K(5)) dut2 (
    .clk(clk), .rst(rst), .abort(abort2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2), .busy(busy2));

  logic [71:0] win_a, win_b, win_c, win_d;

  task automatic test_reset();
    @(negedge clk); #1;
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
    tests++; if (out_data0 !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", out_data0); end
    tests++; if (out_idx0 !== 4'd0) begin fails++; $display("FAIL reset_out_idx: got %0d want 0", out_idx0); end
    tests++; if (out_last0 !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b want 0", out_last0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy0); end
  endtask

  task automatic test_single();
    out_ready0 = 1;
    in_valid0 = 1; in_data0 = win_a; #1;
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL single_accept_ready: got %b want 1", in_ready0); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); in_valid0 = 0; #1;
      tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL single_valid[%0d]: got %b want 1", i, out_valid0); end
      tests++; if (out_data0 !== 8'(8'h11 * (i + 1))) begin fails++; $display("FAIL single_data[%0d]: got %h want %h", i, out_data0, 8'(8'h11 * (i + 1))); end
      tests++; if (out_idx0 !== 4'(i)) begin fails++; $display("FAIL single_idx[%0d]: got %0d want %0d", i, out_idx0, i); end
      tests++; if (out_last0 !== (i == 8)) begin fails++; $display("FAIL single_last[%0d]: got %b want %b", i, out_last0, (i == 8)); end
      tests++; if (in_ready0 !== (i == 8)) begin fails++; $display("FAIL single_in_ready[%0d]: got %b want %b", i, in_ready0, (i == 8)); end
    end
    @(negedge clk); #1;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL single_idle_valid: got %b want 0", out_valid0); end
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL single_idle_ready: got %b want 1", in_ready0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b want 0", busy0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    @(negedge clk);
    out_ready0 = 1; in_valid0 = 1; in_data0 = win_a;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j == 0) in_data0 = win_b;
      if (j == 9) in_valid0 = 0;
      #1;
      exp = (j < 9) ? 8'(8'h11 * (j + 1)) : 8'(8'hA0 + (j - 9));
      tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %b want 1", j, out_valid0); end
      tests++; if (out_data0 !== exp) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", j, out_data0, exp); end
      tests++; if (out_idx0 !== 4'(j % 9)) begin fails++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", j, out_idx0, j % 9); end
      tests++; if (out_last0 !== (j % 9 == 8)) begin fails++; $display("FAIL b2b_last[%0d]: got %b want %b", j, out_last0, (j % 9 == 8)); end
      tests++; if (in_ready0 !== (j % 9 == 8)) begin fails++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", j, in_ready0, (j % 9 == 8)); end
    end
    @(negedge clk); #1;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL b2b_idle_valid: got %b want 0", out_valid0); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int e;
    int cyc;
    pat = 4'b1001; // bit c%4: 1,0,0,1
    @(negedge clk);
    in_valid0 = 1; in_data0 = win_c; out_ready0 = 0;
    e = 0; cyc = 0;
    while (e < 9 && cyc < 40) begin
      @(negedge clk);
      in_valid0 = 0;
      out_ready0 = pat[cyc % 4];
      #1;
      tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL bp_valid[c%0d]: got %b want 1", cyc, out_valid0); end
      tests++; if (out_data0 !== 8'(8'h30 + e)) begin fails++; $display("FAIL bp_data[c%0d]: got %h want %h", cyc, out_data0, 8'(8'h30 + e)); end
      tests++; if (out_idx0 !== 4'(e)) begin fails++; $display("FAIL bp_idx[c%0d]: got %0d want %0d", cyc, out_idx0, e); end
      tests++; if (in_ready0 !== (out_ready0 && e == 8)) begin fails++; $display("FAIL bp_in_ready[c%0d]: got %b want %b", cyc, in_ready0, (out_ready0 && e == 8)); end
      if (out_ready0) e++;
      cyc++;
    end
    tests++; if (e != 9) begin fails++; $display("FAIL bp_timeout: delivered %0d want 9", e); end
    @(negedge clk); out_ready0 = 1; #1;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL bp_idle_valid: got %b want 0", out_valid0); end
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL bp_idle_ready: got %b want 1", in_ready0); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    out_ready0 = 1; in_valid0 = 1; in_data0 = win_a;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid0 = 0;
    end
    #1;
    tests++; if (out_idx0 !== 4'd4) begin fails++; $display("FAIL abort_pre_idx: got %0d want 4", out_idx0); end
    abort0 = 1; in_valid0 = 1; in_data0 = win_d; #1;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL abort_cycle_valid: got %b want 0", out_valid0); end
    tests++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL abort_cycle_ready: got %b want 0", in_ready0); end
    @(negedge clk); abort0 = 0; in_valid0 = 0; #1;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL abort_after_valid: got %b want 0", out_valid0); end
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL abort_after_ready: got %b want 1", in_ready0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL abort_after_busy: got %b want 0", busy0); end
    in_valid0 = 1; in_data0 = win_d;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); in_valid0 = 0; #1;
      tests++; if (out_data0 !== 8'(i + 1)) begin fails++; $display("FAIL abort_new_data[%0d]: got %h want %h", i, out_data0, 8'(i + 1)); end
      tests++; if (out_idx0 !== 4'(i)) begin fails++; $display("FAIL abort_new_idx[%0d]: got %0d want %0d", i, out_idx0, i); end
    end
    @(negedge clk); #1;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL abort_drain_valid: got %b want 0", out_valid0); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready0 = 1; in_valid0 = 1; in_data0 = win_a;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); in_valid0 = 0;
    end
    #1;
    tests++; if (out_idx0 !== 4'd5) begin fails++; $display("FAIL arst_pre_idx: got %0d want 5", out_idx0); end
    #1 rst = 1; #1;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b want 0", out_valid0); end
    tests++; if (out_data0 !== 8'h00) begin fails++; $display("FAIL arst_data: got %h want 00", out_data0); end
    tests++; if (out_idx0 !== 4'd0) begin fails++; $display("FAIL arst_idx: got %0d want 0", out_idx0); end
    tests++; if (out_last0 !== 1'b0) begin fails++; $display("FAIL arst_last: got %b want 0", out_last0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL arst_busy: got %b want 0", busy0); end
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL arst_ready: got %b want 1", in_ready0); end
    @(negedge clk); rst = 0;
    @(negedge clk); #1;
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL arst_release_ready: got %b want 1", in_ready0); end
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL arst_release_valid: got %b want 0", out_valid0); end
  endtask

  task automatic test_k1();
    logic [15:0] v [3];
    v[0] = 16'h1234; v[1] = 16'hBEEF; v[2] = 16'h0F0F;
    @(negedge clk);
    out_ready1 = 1; in_valid1 = 1; in_data1 = v[0]; #1;
    tests++; if (in_ready1 !== 1'b1) begin fails++; $display("FAIL k1_accept_ready: got %b want 1", in_ready1); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j < 2) in_data1 = v[j + 1]; else in_valid1 = 0;
      #1;
      tests++; if (out_valid1 !== 1'b1) begin fails++; $display("FAIL k1_valid[%0d]: got %b want 1", j, out_valid1); end
      tests++; if (out_data1 !== v[j]) begin fails++; $display("FAIL k1_data[%0d]: got %h want %h", j, out_data1, v[j]); end
      tests++; if (out_idx1 !== 1'b0) begin fails++; $display("FAIL k1_idx[%0d]: got %0d want 0", j, out_idx1); end
      tests++; if (out_last1 !== 1'b1) begin fails++; $display("FAIL k1_last[%0d]: got %b want 1", j, out_last1); end
      tests++; if (in_ready1 !== 1'b1) begin fails++; $display("FAIL k1_in_ready[%0d]: got %b want 1", j, in_ready1); end
    end
    @(negedge clk); #1;
    tests++; if (out_valid1 !== 1'b0) begin fails++; $display("FAIL k1_idle_valid: got %b want 0", out_valid1); end
  endtask

  task automatic test_k5();
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[i*8 +: 8] = 8'(i * 3 + 1);
    @(negedge clk);
    out_ready2 = 1; in_valid2 = 1; in_data2 = w;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); in_valid2 = 0; #1;
      tests++; if (out_data2 !== 8'(i * 3 + 1)) begin fails++; $display("FAIL k5_data[%0d]: got %h want %h", i, out_data2, 8'(i * 3 + 1)); end
      tests++; if (out_idx2 !== 5'(i)) begin fails++; $display("FAIL k5_idx[%0d]: got %0d want %0d", i, out_idx2, i); end
      tests++; if (out_last2 !== (i == 24)) begin fails++; $display("FAIL k5_last[%0d]: got %b want %b", i, out_last2, (i == 24)); end
    end
    @(negedge clk); #1;
    tests++; if (out_valid2 !== 1'b0) begin fails++; $display("FAIL k5_idle_valid: got %b want 0", out_valid2); end
    tests++; if (in_ready2 !== 1'b1) begin fails++; $display("FAIL k5_idle_ready: got %b want 1", in_ready2); end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      win_a[i*8 +: 8] = 8'(8'h11 * (i + 1));
      win_b[i*8 +: 8] = 8'(8'hA0 + i);
      win_c[i*8 +: 8] = 8'(8'h30 + i);
      win_d[i*8 +: 8] = 8'(i + 1);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_k1();
    test_k5();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_window_serializer.md
Name: conv_window_serializer

Overview:
- Captures one KxK convolution window (K*K pixels, DATA_W bits each) in a single handshake.
- Streams the window out one element per cycle in row-major order, with its element index and a last flag, to the slow conv MAC.
- Replaces the free-running external select counter of the slow conv path with an internal counter and valid/ready handshakes on both sides.
- Supports back-to-back windows with no bubble, plus a synchronous abort.

Parameters:
- DATA_W, 8, pixel width in bits.
- K, 3, window edge; N = K*K elements per window (K >= 1).
- IDX_W, derived = max(1, clog2(N)), width of the element index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- abort  input  1  synchronous flush: drop the current window and return to IDLE.
- in_valid  input  1  window available.
- in_ready  output  1  window can be accepted this cycle.
- in_data  input  N*DATA_W  flattened window; element i = in_data[i*DATA_W +: DATA_W]; element 0 = top-left, row-major.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the current beat.
- out_data  output  DATA_W  current element.
- out_idx  output  IDX_W  index of the current element, 0..N-1.
- out_last  output  1  asserted when out_idx == N-1.
- busy  output  1  state == SEND.

Behaviour:
- Reset (async, any time, including mid-window):
  - state = IDLE, cnt = 0, window register = 0.
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0, in_ready = 1.
- States are IDLE and SEND.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: capture in_data into the window register, set cnt = 0, go to SEND.
- SEND:
  - out_valid = 1, out_data = win[cnt], out_idx = cnt, out_last = (cnt == N-1).
  - Outputs are driven from registered state; no combinational path from in_data.
  - Beat fires when out_valid && out_ready.
  - On a non-last fire: cnt increments.
  - Without out_ready: all outputs hold stable (AXI-style hold).
- Last beat fires (cnt == N-1 && out_ready):
  - in_ready = 1 in that same cycle, a combinational path from out_ready to in_ready.
  - If in_valid is also high: capture the new window, cnt = 0, stay in SEND. No bubble; throughput is exactly N cycles per window.
  - Otherwise go to IDLE.
- Outside the last-beat fire, in_ready = 0 in SEND. in_data is ignored while not accepted.
- Latency: window accepted at edge t; element 0 is valid in cycle t+1.
- abort:
  - Highest priority after reset. Next edge: state = IDLE, cnt = 0, window register retained.
  - in_ready is forced to 0 and out_valid to 0 during the abort cycle; no capture, no beat fires.
- N == 1 (K = 1): every beat is last; one-cycle-per-window streaming.
- cnt never exceeds N-1.
- Element selection uses the N:1 mux; an out-of-range select yields 0. This is unreachable, but the mux is defined for it.
- No arithmetic on pixel data; values pass through bit-exact.

Decomposition:
- Shared package conv_pkg:
  - default DATA_W and K;
  - a clog2-based index-width function;
  - state encoding constants ST_IDLE = 0 and ST_SEND = 1.
- Sub-module conv_mux_n:
  - parametrised N:1 mux over a flattened bus, parameters DATA_W and N;
  - select of IDX_W bits; output 0 for select >= N.
  - It generalises the slow conv data select and is reused for the weight path.
- The top level holds the FSM, counter, window register and handshake logic.

Test Plan:
- Defaults (K=3, DATA_W=8); reset, then one window 0x11..0x99 (elem i = 0x11*(i+1)), out_ready held 1 -> out_valid for 9 cycles starting the cycle after accept; data 0x11, 0x22, ..., 0x99; idx 0..8; out_last only with 0x99; then IDLE, in_ready = 1.
- Back-to-back: window A then window B, in_valid held high -> B accepted in A's last-beat cycle; B element 0 (0xA0) follows A's element 8 with no gap; 18 consecutive valid beats.
- Backpressure: out_ready toggled 1,0,0,1,... -> out_data/out_idx stable while stalled; every element delivered exactly once, in order; in_ready stays 0 until the last fire.
- Abort at idx 4 -> next cycle out_valid = 0, in_ready = 1; a new window 0x01..0x09 then starts at idx 0 with data 0x01.
- Async reset asserted mid-window (idx 5, between clock edges) -> outputs go to reset values immediately; after release, state is IDLE with in_ready = 1.
- Parameter sweep K=1, DATA_W=16 -> one beat per window with out_last = 1 every beat; K=5 -> 25 beats, out_idx reaches 24 with IDX_W = 5.
